// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the iterative multiply/divide
// engine (mult_div_seq) and its single-iteration datapath (mult_div_step).
//   state_t      - FSM state encoding (IDLE, CALC, FIX, DONE)
//   XLEN_DEFAULT - default operand width
//   DIV0_QUOT    - quotient reported on divide by zero (all ones); sliced to XLEN
package mult_div_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [63:0] DIV0_QUOT = {64{1'b1}};

endpackage

// File: rtl/mult_div_step.sv
// mult_div_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   acc      in  2*XLEN  working accumulator
//                        multiply: {partial_sum, remaining multiplier bits}
//                        divide:   {remainder, dividend bits / quotient bits}
//   operand  in  XLEN    multiplicand magnitude (multiply) / divisor magnitude (divide)
//   is_div   in  1       1 = restoring-division step, 0 = shift-add step
//   acc_next out 2*XLEN  accumulator after this iteration
module mult_div_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    always_comb begin
        // Multiply: add multiplicand to the upper half when the current
        // multiplier LSB is set, then shift the whole thing right with carry.
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: remainder shifted left with the next dividend MSB brought
        // in; it needs one extra bit before the trial subtraction.
        rem_sh = acc[2*XLEN-1:XLEN-1];
        // Only used when rem_sh >= operand, so the result fits in XLEN bits.
        diff   = rem_sh[XLEN-1:0] - operand;

        if (is_div) begin
            if (rem_sh >= {1'b0, operand}) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO registers.
// One iteration per clock over XLEN cycles; done pulses for one cycle when
// hi_out/lo_out carry a fresh result.
// Ports:
//   clk     in  1     rising-edge clock
//   reset   in  1     asynchronous, active-low
//   start   in  1     begin an operation (accepted in IDLE or DONE only)
//   is_div  in  1     1 = divide, 0 = multiply
//   sin     in  1     1 = signed, 0 = unsigned
//   in_1    in  XLEN  multiplicand / dividend
//   in_2    in  XLEN  multiplier / divisor
//   kill    in  1     abandon the in-flight operation
//   busy    out 1     operation in flight (CALC, FIX)
//   done    out 1     one-cycle result strobe
//   hi_out  out XLEN  product high half / remainder
//   lo_out  out XLEN  product low half / quotient
//
// state | meaning
// IDLE  | waiting for start
// CALC  | XLEN shift-add / restoring-divide iterations
// FIX   | sign correction, divide-by-zero override, result registered
// DONE  | done strobe; start here chains straight into CALC
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_div,
    input  logic            sin,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   dvd_raw;
    logic              sign_a;
    logic              sign_b;
    logic              op_div;
    logic              div0;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;

    logic [XLEN-1:0]   mag_1;
    logic [XLEN-1:0]   mag_2;
    logic [2*XLEN-1:0] res;

    // Two's-complement magnitude; -2^(XLEN-1) maps onto itself, which is the
    // correct unsigned magnitude.
    assign mag_1 = (sin && in_1[XLEN-1]) ? -in_1 : in_1;
    assign mag_2 = (sin && in_2[XLEN-1]) ? -in_2 : in_2;

    mult_div_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op_div),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start && !kill) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = kill ? IDLE : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        res = acc;
        if (!op_div) begin
            if (sign_a ^ sign_b) begin
                res = -acc;
            end
        end else if (div0) begin
            res = {dvd_raw, DIV0_QUOT[XLEN-1:0]};
        end else begin
            res[XLEN-1:0]      = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            res[2*XLEN-1:XLEN] = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            dvd_raw <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_div  <= 1'b0;
            div0    <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                // Multiply walks the multiplier (in_2) out of the low half;
                // divide walks the dividend (in_1) out of the low half.
                acc     <= {{XLEN{1'b0}}, (is_div ? mag_1 : mag_2)};
                opnd    <= is_div ? mag_2 : mag_1;
                dvd_raw <= in_1;
                sign_a  <= sin & in_1[XLEN-1];
                sign_b  <= sin & in_2[XLEN-1];
                op_div  <= is_div;
                div0    <= (in_2 == '0);
            end else if (state == CALC && !kill) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end

            if (state == FIX && !kill) begin
                hi_r <= res[2*XLEN-1:XLEN];
                lo_r <= res[XLEN-1:0];
            end
        end
    end

    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);
    assign hi_out = hi_r;
    assign lo_out = lo_r;

endmodule
